kbd_led_tx: RTL
===============

KBD_LED_TX -- requirements
Module: kbd_led_tx

Interface
REQ-001 Parameter ACK_TIMEOUT, default 1_000_000, cycles to wait for a keyboard response after a byte is sent (20 ms at 50 MHz).
REQ-002 Parameter MAX_RETRY, default 3, number of resends allowed per byte before the transaction fails.
REQ-003 CLOCK_50  in  1  single clock; all state updates on its rising edge.
REQ-004 nReset  in  1  reset, asynchronous and active-low.
REQ-005 led_req  in  1  one-cycle request to program the keyboard LEDs.
REQ-006 led_mask  in  3  {caps, num, scroll}, sampled when a request is accepted.
REQ-007 the_command  out  8  byte to PS2_Controller transmitter.
REQ-008 send_command  out  1  transmit request to PS2_Controller.
REQ-009 command_was_sent  in  1  one-cycle pulse from PS2_Controller: byte transmitted.
REQ-010 error_communication_timed_out  in  1  one-cycle pulse from PS2_Controller: transmit failed.
REQ-011 received_data  in  8  byte from keyboard.
REQ-012 received_data_en  in  1  one-cycle strobe qualifying received_data.
REQ-013 busy  out  1  high whenever the state is not IDLE.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 error  out  1  one-cycle pulse on transaction failure.

Function
REQ-016 FSM states: IDLE, TX_ED, ACK_ED, TX_MASK, ACK_MASK.
REQ-017 IDLE with led_req=1 or pending=1: latch mask, clear retry counter, clear pending, go to TX_ED on the next cycle.
REQ-018 TX_ED: the_command=8'hED and send_command=1, held until command_was_sent or error_communication_timed_out.
REQ-019 TX_MASK: the_command={5'b0, caps, num, scroll} from the latched mask, with the same handshake as TX_ED.
REQ-020 the_command stays stable while send_command=1; send_command drops the cycle after command_was_sent.
REQ-021 command_was_sent in a TX state: clear the timeout counter, go to the matching ACK state.
REQ-022 error_communication_timed_out in a TX state: counts as one retry and re-enters the same TX state.
REQ-023 ACK state, received_data_en with 8'hFA: ACK_ED goes to TX_MASK with the retry counter cleared; ACK_MASK pulses done and goes to IDLE.
REQ-024 ACK state, received_data_en with 8'hFE: counts as one retry and returns to the same TX state.
REQ-025 ACK state, any other received byte: ignored; state and timeout counter unchanged.
REQ-026 ACK state: the timeout counter increments each cycle; reaching ACK_TIMEOUT-1 counts as one retry and returns to the TX state.
REQ-027 Retry rule: a retry event with the retry count equal to MAX_RETRY pulses error for one cycle and goes to IDLE; otherwise the count increments.
REQ-028 Retry counter width is clog2(MAX_RETRY+1); the timeout counter width is clog2(ACK_TIMEOUT); neither wraps.
REQ-029 led_req while busy: set pending and overwrite the stored next mask with the latest led_mask; the current transaction is not disturbed.
REQ-030 On done or error with pending=1: IDLE starts the pending transaction on the following cycle (REQ-017).
REQ-031 A simultaneous command_was_sent and error_communication_timed_out: command_was_sent wins.
REQ-032 Simultaneous FA strobe and timeout expiry in an ACK state: the FA strobe wins.
REQ-033 done and error are never high in the same cycle.

Reset
REQ-034 nReset=0 forces asynchronously: state=IDLE, the_command=0, send_command=0, busy=0, done=0, error=0, pending=0, both counters=0, latched masks=0.
REQ-035 Reset asserted mid-transaction abandons the transaction with no done or error pulse; there is no request replay after release.

Verification
REQ-036 led_req with mask=3'b101, model ACKs both bytes -> bytes ED then 05 sent, done pulses once, busy falls on the same cycle.
REQ-037 Model returns FE after ED -> ED resent, then the flow completes with done; error never pulses.
REQ-038 Model never responds, MAX_RETRY=3 -> ED sent 4 times, each attempt separated by ACK_TIMEOUT cycles; error pulses once; state returns to IDLE.
REQ-039 led_req mask=001 then, while busy, led_req mask=010 and mask=100 -> two transactions total, the second sends mask byte 04.
REQ-040 Stray byte 8'h1C during ACK_ED, then FA -> the 1C byte is ignored and the flow proceeds to TX_MASK.
REQ-041 nReset pulsed during ACK_MASK -> all outputs 0 immediately, no done or error pulse; a new led_req afterward completes normally.

Source files
------------

// File: rtl/kbd_led_tx.sv
// kbd_led_tx: programs PS/2 keyboard LEDs by sending ED + mask, with ACK/resend/timeout handling.
module kbd_led_tx #(
    parameter int ACK_TIMEOUT = 1_000_000,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLOCK_50,
    input  logic       nReset,
    input  logic       led_req,
    input  logic [2:0] led_mask,
    output logic [7:0] the_command,
    output logic       send_command,
    input  logic       command_was_sent,
    input  logic       error_communication_timed_out,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    output logic       busy,
    output logic       done,
    output logic       error
);
    localparam int TW = ACK_TIMEOUT > 1 ? $clog2(ACK_TIMEOUT) : 1;
    localparam int RW = MAX_RETRY > 0 ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] TX_ED    = 3'd1;
    localparam logic [2:0] ACK_ED   = 3'd2;
    localparam logic [2:0] TX_MASK  = 3'd3;
    localparam logic [2:0] ACK_MASK = 3'd4;
    logic [2:0]    state;
    logic [2:0]    mask;
    logic [2:0]    next_mask;
    logic          pending;
    logic [RW-1:0] retry_cnt;
    logic [TW-1:0] to_cnt;
    logic          tx_st;
    logic          ack_st;
    logic          fa;
    logic          retry_ev;
    logic          last;
    logic          expired;
    logic [2:0]    tx_of;
    always_comb begin
        tx_st        = state == TX_ED || state == TX_MASK;
        ack_st       = state == ACK_ED || state == ACK_MASK;
        busy         = state != IDLE;
        send_command = tx_st;
        the_command  = state == TX_ED ? 8'hED : state == TX_MASK ? {5'b0, mask} : 8'h00;
        tx_of        = (state == TX_MASK || state == ACK_MASK) ? TX_MASK : TX_ED;
        last         = retry_cnt == RW'(MAX_RETRY);
        expired      = to_cnt == TW'(ACK_TIMEOUT - 1);
        fa           = ack_st && received_data_en && received_data == 8'hFA;
        // a stray byte freezes the timeout for that cycle, so only an idle strobe cycle can expire
        retry_ev     = (tx_st && error_communication_timed_out && !command_was_sent) ||
                       (ack_st && ((received_data_en && received_data == 8'hFE) ||
                                   (!received_data_en && expired)));
    end
    always_ff @(posedge CLOCK_50 or negedge nReset) begin
        if (!nReset) begin
            state     <= IDLE;
            mask      <= 3'b0;
            next_mask <= 3'b0;
            pending   <= 1'b0;
            retry_cnt <= '0;
            to_cnt    <= '0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            if (busy && led_req) begin
                pending   <= 1'b1;
                next_mask <= led_mask;
            end
            if (state == IDLE) begin
                if (led_req || pending) begin
                    mask      <= led_req ? led_mask : next_mask;
                    retry_cnt <= '0;
                    pending   <= 1'b0;
                    state     <= TX_ED;
                end
            end else if (tx_st && command_was_sent) begin
                to_cnt <= '0;
                state  <= state == TX_ED ? ACK_ED : ACK_MASK;
            end else if (fa) begin
                to_cnt <= '0;
                if (state == ACK_ED) begin
                    retry_cnt <= '0;
                    state     <= TX_MASK;
                end else begin
                    done  <= 1'b1;
                    state <= IDLE;
                end
            end else if (retry_ev) begin
                to_cnt <= '0;
                if (last) begin
                    error <= 1'b1;
                    state <= IDLE;
                end else begin
                    retry_cnt <= retry_cnt + RW'(1);
                    state     <= tx_of;
                end
            end else if (ack_st && !received_data_en) begin
                to_cnt <= to_cnt + TW'(1);
            end
        end
    end
endmodule
